decoder_3to8_reg: RTL and testbench
===================================

// Module: decoder_3to8_reg
//
// PURPOSE
//   Registered 3-to-8 one-hot line decoder with enable. Drives output line
//   F[A] high when enable E is high; drives all lines low when E is low.
//   Sits between control/address logic and per-line selects: chip selects,
//   register-bank strobes, mux selects.
//   Outputs are flopped, so downstream logic sees glitch-free selects.
//
// PARAMETERS
//   IN_W   3            select width; fixed at 3 for this block
//   OUT_W  1<<IN_W = 8  localparam; one-hot output width, not overridable
//
// PORTS
//   clk    in   1  system clock; all state updates on rising edge
//   rst_n  in   1  asynchronous, active-low reset
//   E      in   1  decode enable; 1 = decode A, 0 = all outputs inactive
//   A      in   3  binary select index, 0..7
//   F      out  8  one-hot decoded lines; F[i] active iff E=1 and A=i
//   valid  out  1  registered copy of E; 1 when F carries a decoded line
//
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous):
//     - F = 8'h00 (8'hFF under DECODER_ACTIVE_LOW_EN); valid = 0.
//     - Held while rst_n is low.
//     - First decode occurs on the first rising clk after rst_n deasserts.
//   - Latency: 1 clk.
//     - F and valid update on each rising edge from E and A sampled at that edge.
//     - No combinational path from inputs to outputs.
//   - Decode rule, registered every cycle:
//     - E=1: F_next = 8'b1 << A, so exactly one bit is set.
//     - E=0: F_next = 8'h00, regardless of A.
//     - valid_next = E.
//   - Full truth table, E=1:
//     - A=0 -> 01, A=1 -> 02, A=2 -> 04, A=3 -> 08
//     - A=4 -> 10, A=5 -> 20, A=6 -> 40, A=7 -> 80 (hex)
//   - Invariant: F is either zero or exactly one-hot. Never more than one bit set.
//   - A and E changing on the same edge: the new pair is decoded together.
//     There is no intermediate state.
//   - X/Z on A with E=1: no functional requirement. Implementation must not
//     assert more than one bit for any 0/1 value of A.
//   - Reset mid-operation: outputs go to the reset value immediately,
//     without waiting for clk. Previous decode is discarded.
//   - No handshake. The decoder accepts a new select every cycle.
//
// CONFIGURATION
//   DECODER_ACTIVE_LOW_EN
//   - Defined: F polarity is inverted (74x138 style).
//     - Active line = 0, inactive lines = 1.
//     - E=0 or reset -> F = 8'hFF.
//     - E=1, A=2 -> F = 8'hFB.
//     - valid polarity is unchanged (active high).
//   - Undefined (default): active-high one-hot as described above.
//
// TESTING
//   - Hold rst_n=0, E=1, A=5 for 3 clk -> F=00, valid=0. Release -> next edge F=20, valid=1.
//   - E=1, sweep A=0..7, one per 2 clk -> F = 01,02,04,08,10,20,40,80, each 1 clk after A changes.
//   - E=1 A=3 then E=0 A=2 -> F=08 then F=00, valid 1->0. Never shows 04.
//   - Assert rst_n=0 mid-cycle while F=80 -> F=00 before the next clk edge.
//   - Random E/A for 1000 clk -> F == (E_d ? 1<<A_d : 0) and $onehot0(F) every cycle,
//     where E_d, A_d are the inputs delayed by 1 clk.
//   - With DECODER_ACTIVE_LOW_EN: reset -> FF; E=1 A=0 -> FE; E=0 -> FF.

Source files
------------

// File: rtl/decoder_3to8_reg.sv
// Registered 3-to-8 one-hot line decoder with enable; outputs are flopped for glitch-free selects.
// Define DECODER_ACTIVE_LOW_EN for 74x138-style inverted F polarity (valid stays active high).
module decoder_3to8_reg #(
   parameter int IN_W = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   E,
   input  logic [IN_W-1:0]        A,
   output logic [(1 << IN_W)-1:0] F,
   output logic                   valid
);

   localparam int OUT_W = 1 << IN_W;

   // XOR mask applied to the active-high one-hot word; also the idle/reset value of F.
`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] POL_MASK = '1;
`else
   localparam logic [OUT_W-1:0] POL_MASK = '0;
`endif

   logic [OUT_W-1:0] line_sel;
   logic [OUT_W-1:0] f_next;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      line_sel = '0;
      if (E) begin
         line_sel = OUT_W'(1) << A;
      end
      f_next = line_sel ^ POL_MASK;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F     <= POL_MASK;
         valid <= 1'b0;
      end else begin
         F     <= f_next;
         valid <= E;
      end
   end

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Self-checking bench for decoder_3to8_reg: vector table, reset/corner sequences and random traffic
// compared against a behavioural model (polarity follows DECODER_ACTIVE_LOW_EN).
module tb_decoder_3to8_reg;

   logic       clk;
   logic       rst_n;
   logic       E;
   logic [2:0] A;
   logic [7:0] F;
   logic       valid;

   int n_checks = 0;
   int n_fail   = 0;

   decoder_3to8_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .E     (E),
      .A     (A),
      .F     (F),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       e;
      logic [2:0] a;
      logic [7:0] f;
      logic       v;
   } vec_t;

   // Maps an active-high line pattern onto the pin polarity of the build under test.
   function automatic logic [7:0] pol(input logic [7:0] hi);
`ifdef DECODER_ACTIVE_LOW_EN
      return ~hi;
`else
      return hi;
`endif
   endfunction

   // Reference: line a of 8 is selected when enabled, otherwise nothing is selected.
   function automatic logic [7:0] model_f(input logic e, input int a);
      int val;
      val = e ? (2 ** a) : 0;
      return pol(val[7:0]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive a new pair away from the rising edge, then sample just after the edge that captures it.
   task automatic step(input logic e, input logic [2:0] a);
      @(negedge clk);
      E = e;
      A = a;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[10];

   initial begin
      rst_n = 1'b0;
      E     = 1'b1;
      A     = 3'd5;

      // Reset held for 3 clocks with E=1, A=5: outputs stay idle.
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_F", F, pol(8'h00));
         check("reset_valid", valid, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_F", F, pol(8'h20));
      check("post_reset_valid", valid, 1'b1);

      // Truth table sweep plus disabled entries, each held for two clocks.
      vecs[0] = '{1'b1, 3'd0, 8'h01, 1'b1};
      vecs[1] = '{1'b1, 3'd1, 8'h02, 1'b1};
      vecs[2] = '{1'b1, 3'd2, 8'h04, 1'b1};
      vecs[3] = '{1'b1, 3'd3, 8'h08, 1'b1};
      vecs[4] = '{1'b1, 3'd4, 8'h10, 1'b1};
      vecs[5] = '{1'b1, 3'd5, 8'h20, 1'b1};
      vecs[6] = '{1'b1, 3'd6, 8'h40, 1'b1};
      vecs[7] = '{1'b1, 3'd7, 8'h80, 1'b1};
      vecs[8] = '{1'b0, 3'd7, 8'h00, 1'b0};
      vecs[9] = '{1'b0, 3'd0, 8'h00, 1'b0};
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].e, vecs[i].a);
         check($sformatf("vec%0d_F", i), F, pol(vecs[i].f));
         check($sformatf("vec%0d_valid", i), valid, vecs[i].v);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_hold_F", i), F, pol(vecs[i].f));
      end

      // E and A change together: 08 goes straight to 00, never 04.
      step(1'b1, 3'd3);
      check("seq_en_F", F, pol(8'h08));
      check("seq_en_valid", valid, 1'b1);
      step(1'b0, 3'd2);
      check("seq_dis_F", F, pol(8'h00));
      check("seq_dis_valid", valid, 1'b0);

      // Asynchronous reset mid-cycle while F=80.
      step(1'b1, 3'd7);
      check("pre_async_F", F, pol(8'h80));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_F", F, pol(8'h00));
      check("async_reset_valid", valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("after_async_F", F, pol(8'h80));

      // Random traffic against the reference model, one new pair per clock.
      for (int i = 0; i < 1000; i++) begin
         logic       re;
         logic [2:0] ra;
         logic [7:0] line_hi;
         re = 1'($urandom_range(0, 1));
         ra = 3'($urandom_range(0, 7));
         step(re, ra);
         line_hi = pol(F);
         check("rand_F", F, model_f(re, int'(ra)));
         check("rand_valid", valid, re);
         check("rand_onehot0", 32'($onehot0(line_hi)), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
